pipe_mips32: RTL and testbench
==============================

Name: pipe_mips32

Overview:
- Five-stage in-order pipelined processor for a reduced MIPS32 subset: IF, ID, EX, MEM, WB.
- Single clock. Unified word-addressed instruction/data memory.
- Standalone top-level CPU core. Programs are preloaded by hierarchical access to internal arrays Mem and Reg.
- Internal state PC, HALTED and TAKEN_BRANCH uses exactly these names and is hierarchically accessible.

Parameters:
- MEM_WORDS, 1024: depth of Mem in 32-bit words. The address is the ALU result modulo MEM_WORDS.

Ports:
- clk1  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- halted  output  1  mirrors internal HALTED.

Behaviour:
- Storage:
  - Reg[0:31] is 32x32. Reads of R0 always return 0; writes to R0 are ignored.
  - Mem[0:MEM_WORDS-1] is 32-bit.
  - rst never clears Reg or Mem.
- Reset (synchronous):
  - PC=0, HALTED=0, TAKEN_BRANCH=0.
  - All pipeline latches are loaded with NOP; latch values are 0.
- Instruction format:
  - opcode=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], imm=IR[15:0] sign-extended to 32 bits.
- RR ops (rd <= rs op rt):
  - ADD=000000, SUB=000001, AND=000010, OR=000011.
  - SLT=000100: signed compare, result 1/0.
  - MUL=000101: low 32 bits of the product.
- RM ops (rt <= rs op imm):
  - ADDI=001010, SUBI=001011.
  - SLTI=001100: signed compare.
- Memory ops:
  - LW=001000: rt <= Mem[rs+imm].
  - SW=001001: Mem[rs+imm] <= rt.
- Branch ops:
  - BNEQZ=001101: taken if rs!=0.
  - BEQZ=001110: taken if rs==0.
  - Target = (branch PC + 1) + imm.
- HLT=111111.
- All other opcodes are NOPs: no register or memory write.
- Arithmetic is 32-bit two's complement with wrap-around. PC counts words and increments by 1.
- IF: IR <= Mem[PC]; NPC <= PC+1; PC <= PC+1 unless redirected or halted.
- ID:
  - Reads rs and rt.
  - Register file is write-before-read: a WB write in the same cycle is visible to ID.
- Forwarding:
  - Operands entering EX are forwarded from EX/MEM (ALU result) and MEM/WB (ALU result or load data).
  - The youngest producer wins. A destination of R0 is never forwarded.
  - No stall logic exists. A load followed by a dependent instruction at distance 1 is unsupported (undefined result); distance >=2 works.
- Branches resolve in EX:
  - On a taken branch: PC <= target; the two younger instructions in IF/ID and ID/EX become NOPs; TAKEN_BRANCH=1 for that cycle, else 0.
  - A not-taken branch has no penalty.
  - A squashed SW or HLT has no effect.
- Halt:
  - When HLT is in ID, PC freezes and NOPs are injected behind it.
  - When HLT reaches WB, HALTED <= 1.
  - While HALTED=1, PC, Reg, Mem and the latches are frozen until rst.
  - Instructions older than HLT complete before HALTED rises.
- No branch delay slot: instructions after a taken branch never commit.
- Writes to Mem by SW occur in MEM. Register writes occur in WB.

Test Plan:
- Reg[k]=k; program ADDI R1,R0,10; OR R20,R20,R20 (x2); ADD R3,R1,R2; HLT -> R1=10, R3=12, halted=1.
- Forwarding: ADDI R1,R0,5; ADD R2,R1,R1; SUB R3,R2,R1 back-to-back -> R2=10, R3=5.
- Load/store: Mem[120]=85; LW R2,0(R1) with R1=120; dummy; ADDI R2,R2,45; SW R2,1(R1); HLT -> Mem[121]=130.
- Factorial: Mem[0..10] = 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000 (hex); Mem[200]=7.
  - Required: Mem[198]=5040, Mem[200]=7, R2=5040, halted=1 within 100 cycles.
  - SW and HLT fetched behind each taken BNEQZ must not execute early.
- Branch flush: BEQZ R0,+2 followed by ADDI R5,R0,1 and ADDI R6,R0,1 -> both R5 and R6 unchanged.
- Reset mid-run: assert rst for 1 cycle during the factorial loop -> PC=0, HALTED=0, pipeline NOPs. Rerun with Mem[200] reset to 7 and R0 preserved -> same final Mem[198]=5040.

Source files
------------

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset pipeline (IF/ID/EX/MEM/WB) with forwarding
// into EX, branch resolution in EX, and a halt that lets older work drain first.
module pipe_mips32 #(
    parameter int MEM_WORDS = 1024
) (
    input  logic clk1,
    input  logic rst,
    output logic halted
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Architectural state, reachable hierarchically for program preload.
    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    // Pipeline latches.
    logic [31:0] r_ifIdIr;
    logic [31:0] r_ifIdNpc;
    logic [31:0] r_idExIr;
    logic [31:0] r_idExNpc;
    logic [31:0] r_idExA;
    logic [31:0] r_idExB;
    logic [31:0] r_idExImm;
    logic [31:0] r_exMemIr;
    logic [31:0] r_exMemAluOut;
    logic [31:0] r_exMemB;
    logic [31:0] r_memWbIr;
    logic [31:0] r_memWbAluOut;
    logic [31:0] r_memWbLmd;

    logic [AW-1:0] w_pcAddr;
    logic [AW-1:0] w_memAddr;
    logic [4:0]    w_idRs;
    logic [4:0]    w_idRt;
    logic [31:0]   w_idRsVal;
    logic [31:0]   w_idRtVal;
    logic [31:0]   w_idImm;
    logic [4:0]    w_exRs;
    logic [4:0]    w_exRt;
    logic [4:0]    w_exMemDest;
    logic [4:0]    w_wbDest;
    logic [31:0]   w_wbValue;
    logic [31:0]   w_fwdA;
    logic [31:0]   w_fwdB;
    logic [31:0]   w_aluOut;
    logic          w_branchTaken;
    logic [31:0]   w_branchTarget;
    logic          w_haltInFlight;

    // Register written by an instruction; 0 means it writes nothing.
    function automatic logic [4:0] destOf(input logic [31:0] ir);
        logic [4:0] dest;
        dest = 5'd0;
        case (ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: dest = ir[15:11];
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW:              dest = ir[20:16];
            default:                                       dest = 5'd0;
        endcase
        return dest;
    endfunction

    function automatic logic isHlt(input logic [31:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction

    assign halted    = HALTED;
    assign w_pcAddr  = AW'(PC % 32'(MEM_WORDS));
    assign w_memAddr = AW'(r_exMemAluOut % 32'(MEM_WORDS));

    assign w_wbDest    = destOf(r_memWbIr);
    assign w_wbValue   = (r_memWbIr[31:26] == OP_LW) ? r_memWbLmd : r_memWbAluOut;
    assign w_exMemDest = destOf(r_exMemIr);

    // Once HLT is decoded, fetch stops so nothing younger can enter behind it.
    assign w_haltInFlight = isHlt(r_ifIdIr) | isHlt(r_idExIr) |
                            isHlt(r_exMemIr) | isHlt(r_memWbIr);

    // ID register read; a same-cycle WB write is visible here.
    always_comb begin
        w_idRs    = r_ifIdIr[25:21];
        w_idRt    = r_ifIdIr[20:16];
        w_idImm   = {{16{r_ifIdIr[15]}}, r_ifIdIr[15:0]};
        w_idRsVal = Reg[w_idRs];
        w_idRtVal = Reg[w_idRt];
        if (w_wbDest != 5'd0 && w_wbDest == w_idRs) begin
            w_idRsVal = w_wbValue;
        end
        if (w_wbDest != 5'd0 && w_wbDest == w_idRt) begin
            w_idRtVal = w_wbValue;
        end
        if (w_idRs == 5'd0) begin
            w_idRsVal = 32'd0;
        end
        if (w_idRt == 5'd0) begin
            w_idRtVal = 32'd0;
        end
    end

    // EX operand forwarding; EX/MEM is checked last so the youngest producer wins.
    always_comb begin
        w_exRs = r_idExIr[25:21];
        w_exRt = r_idExIr[20:16];
        w_fwdA = r_idExA;
        w_fwdB = r_idExB;
        if (w_wbDest != 5'd0 && w_wbDest == w_exRs) begin
            w_fwdA = w_wbValue;
        end
        if (w_wbDest != 5'd0 && w_wbDest == w_exRt) begin
            w_fwdB = w_wbValue;
        end
        if (w_exMemDest != 5'd0 && w_exMemDest == w_exRs) begin
            w_fwdA = r_exMemAluOut;
        end
        if (w_exMemDest != 5'd0 && w_exMemDest == w_exRt) begin
            w_fwdB = r_exMemAluOut;
        end
    end

    always_comb begin
        w_aluOut       = 32'd0;
        w_branchTaken  = 1'b0;
        w_branchTarget = r_idExNpc + r_idExImm;
        case (r_idExIr[31:26])
            OP_ADD:        w_aluOut = w_fwdA + w_fwdB;
            OP_SUB:        w_aluOut = w_fwdA - w_fwdB;
            OP_AND:        w_aluOut = w_fwdA & w_fwdB;
            OP_OR:         w_aluOut = w_fwdA | w_fwdB;
            OP_SLT:        w_aluOut = {31'd0, $signed(w_fwdA) < $signed(w_fwdB)};
            OP_MUL:        w_aluOut = w_fwdA * w_fwdB;
            OP_ADDI:       w_aluOut = w_fwdA + r_idExImm;
            OP_SUBI:       w_aluOut = w_fwdA - r_idExImm;
            OP_SLTI:       w_aluOut = {31'd0, $signed(w_fwdA) < $signed(r_idExImm)};
            OP_LW, OP_SW:  w_aluOut = w_fwdA + r_idExImm;
            OP_BNEQZ:      w_branchTaken = (w_fwdA != 32'd0);
            OP_BEQZ:       w_branchTaken = (w_fwdA == 32'd0);
            default:       w_aluOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            PC            <= 32'd0;
            HALTED        <= 1'b0;
            TAKEN_BRANCH  <= 1'b0;
            r_ifIdIr      <= NOP;
            r_ifIdNpc     <= 32'd0;
            r_idExIr      <= NOP;
            r_idExNpc     <= 32'd0;
            r_idExA       <= 32'd0;
            r_idExB       <= 32'd0;
            r_idExImm     <= 32'd0;
            r_exMemIr     <= NOP;
            r_exMemAluOut <= 32'd0;
            r_exMemB      <= 32'd0;
            r_memWbIr     <= NOP;
            r_memWbAluOut <= 32'd0;
            r_memWbLmd    <= 32'd0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= w_branchTaken;

            if (w_branchTaken) begin
                PC        <= w_branchTarget;
                r_ifIdIr  <= NOP;
                r_ifIdNpc <= 32'd0;
            end else if (w_haltInFlight) begin
                r_ifIdIr  <= NOP;
                r_ifIdNpc <= 32'd0;
            end else begin
                PC        <= PC + 32'd1;
                r_ifIdIr  <= Mem[w_pcAddr];
                r_ifIdNpc <= PC + 32'd1;
            end

            // A taken branch squashes the instruction being decoded.
            if (w_branchTaken) begin
                r_idExIr  <= NOP;
                r_idExNpc <= 32'd0;
                r_idExA   <= 32'd0;
                r_idExB   <= 32'd0;
                r_idExImm <= 32'd0;
            end else begin
                r_idExIr  <= r_ifIdIr;
                r_idExNpc <= r_ifIdNpc;
                r_idExA   <= w_idRsVal;
                r_idExB   <= w_idRtVal;
                r_idExImm <= w_idImm;
            end

            r_exMemIr     <= r_idExIr;
            r_exMemAluOut <= w_aluOut;
            r_exMemB      <= w_fwdB;

            r_memWbIr     <= r_exMemIr;
            r_memWbAluOut <= r_exMemAluOut;
            r_memWbLmd    <= Mem[w_memAddr];

            if (isHlt(r_memWbIr)) begin
                HALTED <= 1'b1;
            end
        end
    end

    // Architectural writes: stores in MEM, register results in WB.
    always_ff @(posedge clk1) begin
        if (!rst && !HALTED) begin
            if (r_exMemIr[31:26] == OP_SW) begin
                Mem[w_memAddr] <= r_exMemB;
            end
            if (w_wbDest != 5'd0) begin
                Reg[w_wbDest] <= w_wbValue;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: single-instruction vector table plus hand-written
// programs for forwarding, load/store, branch flush, factorial and mid-run reset.
module tb_pipe_mips32;

    localparam int MEM_WORDS = 1024;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [31:0] HLT_WORD = 32'hFC00_0000;

    logic clk1 = 1'b0;
    logic rst;
    logic halted;

    int checks = 0;
    int errors = 0;

    int          watchAddr = -1;
    logic [31:0] watchGood = 32'd0;
    logic        watchBad  = 1'b0;

    logic [31:0] factProg [0:10] = '{
        32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
        32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
        32'h3460fffc, 32'h2542fffe, 32'hfc000000
    };

    typedef struct {
        logic [31:0] instr;
        logic [31:0] aVal;
        logic [31:0] bVal;
        int          dstReg;
        logic [31:0] expVal;
    } vec_t;

    vec_t vecs [16];

    pipe_mips32 #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk1   (clk1),
        .rst    (rst),
        .halted (halted)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] encR(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Holds rst for a cycle, then clears memory and sets Reg[k]=k.
    task automatic beginReset();
        rst = 1'b1;
        @(negedge clk1);
        for (int a = 0; a < MEM_WORDS; a++) dut.Mem[a] = 32'd0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    endtask

    task automatic runUntilHalt(input int maxCycles, output int used);
        rst  = 1'b0;
        used = 0;
        while (!halted && used < maxCycles) begin
            @(negedge clk1);
            used++;
            if (watchAddr >= 0 && dut.Mem[watchAddr] != 32'd0 &&
                dut.Mem[watchAddr] != watchGood) begin
                watchBad = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int used;
        beginReset();
        dut.Reg[1] = v.aVal;
        dut.Reg[2] = v.bVal;
        dut.Reg[3] = 32'hDEAD_BEEF;
        dut.Mem[0] = v.instr;
        dut.Mem[1] = HLT_WORD;
        runUntilHalt(50, used);
    endtask

    task automatic loadFactorial();
        for (int i = 0; i < 11; i++) dut.Mem[i] = factProg[i];
        dut.Mem[200] = 32'd7;
        dut.Mem[198] = 32'd0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int used;
        rst = 1'b1;

        vecs[0]  = '{encR(OP_ADD, 1, 2, 3), 32'd5,          32'd7,          3, 32'd12};
        vecs[1]  = '{encR(OP_ADD, 1, 2, 3), 32'hFFFF_FFFF,  32'd2,          3, 32'd1};
        vecs[2]  = '{encR(OP_SUB, 1, 2, 3), 32'd3,          32'd5,          3, 32'hFFFF_FFFE};
        vecs[3]  = '{encR(OP_AND, 1, 2, 3), 32'hF0F0_1234,  32'h0FF0_FFFF,  3, 32'h00F0_1234};
        vecs[4]  = '{encR(OP_OR,  1, 2, 3), 32'hF000_0000,  32'h0000_000F,  3, 32'hF000_000F};
        vecs[5]  = '{encR(OP_SLT, 1, 2, 3), 32'hFFFF_FFFF,  32'd1,          3, 32'd1};
        vecs[6]  = '{encR(OP_SLT, 1, 2, 3), 32'd5,          32'hFFFF_FFFD,  3, 32'd0};
        vecs[7]  = '{encR(OP_MUL, 1, 2, 3), 32'd12345,      32'd1000,       3, 32'd12345000};
        vecs[8]  = '{encR(OP_MUL, 1, 2, 3), 32'h0001_0000,  32'h0001_0001,  3, 32'h0001_0000};
        vecs[9]  = '{encI(OP_ADDI, 1, 3, 16'hFFFF), 32'd100, 32'd0,         3, 32'd99};
        vecs[10] = '{encI(OP_SUBI, 1, 3, 16'd1),    32'd0,   32'd0,         3, 32'hFFFF_FFFF};
        vecs[11] = '{encI(OP_SLTI, 1, 3, 16'hFFFC), 32'hFFFF_FFFB, 32'd0,   3, 32'd1};
        vecs[12] = '{encI(OP_SLTI, 1, 3, 16'd7),    32'd7,   32'd0,         3, 32'd0};
        vecs[13] = '{encR(6'b000110, 1, 2, 3),      32'd4,   32'd9,         3, 32'hDEAD_BEEF};
        vecs[14] = '{encI(OP_ADDI, 1, 0, 16'd5),    32'd100, 32'd0,         0, 32'd0};
        vecs[15] = '{encI(6'b010000, 1, 3, 16'd5),  32'd4,   32'd9,         3, 32'hDEAD_BEEF};

        beginReset();
        checkOutput("reset_pc", dut.PC, 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_taken", 32'(dut.TAKEN_BRANCH), 32'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_halted", i), 32'(halted), 32'd1);
            checkOutput($sformatf("vec%0d_r%0d", i, vecs[i].dstReg),
                        dut.Reg[vecs[i].dstReg], vecs[i].expVal);
        end

        // Distance-3 dependency through the register file, then halt freeze.
        beginReset();
        dut.Mem[0] = encI(OP_ADDI, 0, 1, 16'd10);
        dut.Mem[1] = encR(OP_OR, 20, 20, 20);
        dut.Mem[2] = encR(OP_OR, 20, 20, 20);
        dut.Mem[3] = encR(OP_ADD, 1, 2, 3);
        dut.Mem[4] = HLT_WORD;
        runUntilHalt(100, used);
        checkOutput("basic_halted", 32'(halted), 32'd1);
        checkOutput("basic_r1", dut.Reg[1], 32'd10);
        checkOutput("basic_r3", dut.Reg[3], 32'd12);
        checkOutput("basic_pc", dut.PC, 32'd5);
        repeat (5) @(negedge clk1);
        checkOutput("frozen_pc", dut.PC, 32'd5);
        checkOutput("frozen_halted", 32'(halted), 32'd1);

        // Back-to-back forwarding from EX/MEM and MEM/WB.
        beginReset();
        dut.Mem[0] = encI(OP_ADDI, 0, 1, 16'd5);
        dut.Mem[1] = encR(OP_ADD, 1, 1, 2);
        dut.Mem[2] = encR(OP_SUB, 2, 1, 3);
        dut.Mem[3] = HLT_WORD;
        runUntilHalt(100, used);
        checkOutput("fwd_r2", dut.Reg[2], 32'd10);
        checkOutput("fwd_r3", dut.Reg[3], 32'd5);

        // Load, distance-2 use, store with forwarded data.
        beginReset();
        dut.Reg[1]   = 32'd120;
        dut.Mem[120] = 32'd85;
        dut.Mem[0] = encI(OP_LW, 1, 2, 16'd0);
        dut.Mem[1] = encR(OP_OR, 20, 20, 20);
        dut.Mem[2] = encI(OP_ADDI, 2, 2, 16'd45);
        dut.Mem[3] = encI(OP_SW, 1, 2, 16'd1);
        dut.Mem[4] = HLT_WORD;
        runUntilHalt(100, used);
        checkOutput("ldst_mem121", dut.Mem[121], 32'd130);
        checkOutput("ldst_r2", dut.Reg[2], 32'd130);

        // Not-taken BNEQZ, then taken BEQZ squashing two ADDIs.
        beginReset();
        dut.Mem[0] = encI(OP_BNEQZ, 0, 0, 16'd5);
        dut.Mem[1] = encI(OP_BEQZ, 0, 0, 16'd2);
        dut.Mem[2] = encI(OP_ADDI, 0, 5, 16'd1);
        dut.Mem[3] = encI(OP_ADDI, 0, 6, 16'd1);
        dut.Mem[4] = encI(OP_ADDI, 0, 7, 16'd3);
        dut.Mem[5] = HLT_WORD;
        runUntilHalt(100, used);
        checkOutput("flush_halted", 32'(halted), 32'd1);
        checkOutput("flush_r5", dut.Reg[5], 32'd5);
        checkOutput("flush_r6", dut.Reg[6], 32'd6);
        checkOutput("flush_r7", dut.Reg[7], 32'd3);

        // Factorial of 7; Mem[198] must only ever receive the final product.
        beginReset();
        loadFactorial();
        watchAddr = 198;
        watchGood = 32'd5040;
        watchBad  = 1'b0;
        runUntilHalt(100, used);
        watchAddr = -1;
        checkOutput("fact_halted", 32'(halted), 32'd1);
        checkOutput("fact_mem198", dut.Mem[198], 32'd5040);
        checkOutput("fact_mem200", dut.Mem[200], 32'd7);
        checkOutput("fact_r2", dut.Reg[2], 32'd5040);
        checkOutput("fact_early_sw", 32'(watchBad), 32'd0);

        // One-cycle reset in the middle of the loop, then a clean rerun.
        beginReset();
        loadFactorial();
        rst = 1'b0;
        repeat (20) @(negedge clk1);
        checkOutput("midrun_not_halted", 32'(halted), 32'd0);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        checkOutput("midrun_pc", dut.PC, 32'd0);
        checkOutput("midrun_halted", 32'(halted), 32'd0);
        checkOutput("midrun_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
        checkOutput("midrun_ifid", dut.r_ifIdIr, 32'd0);
        checkOutput("midrun_exmem", dut.r_exMemIr, 32'd0);
        dut.Mem[200] = 32'd7;
        dut.Mem[198] = 32'd0;
        @(negedge clk1);
        runUntilHalt(100, used);
        checkOutput("rerun_halted", 32'(halted), 32'd1);
        checkOutput("rerun_mem198", dut.Mem[198], 32'd5040);
        checkOutput("rerun_r0", dut.Reg[0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
